// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: tracks the producers in E/M/W and derives operand
// bypass selects, the D-stage stall/flush and a running stall counter.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             use_rs_bD,
  input  logic             use_rt_bD,
  input  logic             use_rs_jrD,
  input  logic             use_rt_jiD,
  input  logic             use_rs_aluD,
  input  logic             use_rt_aluD,
  input  logic             use_rt_memD,
  input  logic [4:0]       dstD,
  input  logic [1:0]       srcD,
  output logic [1:0]       bypass_rs_b,
  output logic [1:0]       bypass_rt_b,
  output logic [1:0]       bypass_rs_jr,
  output logic [1:0]       bypass_rt_ji,
  output logic [1:0]       bypass_rs_alu,
  output logic [1:0]       bypass_rt_alu,
  output logic             bypass_rt_mem,
  output logic             stall,
  output logic             flushE,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PC8  = 2'd1,
    SRC_ALU  = 2'd2,
    SRC_LOAD = 2'd3
  } src_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    src_t       src;
  } stage_t;

  stage_t     e_q, m_q, w_q;
  logic [4:0] rs_e, rt_e, rt_m;
  logic       use_rs_alu_e, use_rt_alu_e, use_rt_mem_e, use_rt_mem_m;

  function automatic logic hit(input stage_t s, input logic [4:0] r);
    return s.valid && (s.src != SRC_NONE) && (s.dst == r) && (r != 5'd0);
  endfunction

  // D-stage consumer: returns {stall, select}; jump selects are shifted by one
  // because pc_plus8E occupies code 1.
  function automatic logic [2:0] d_fwd(input logic use_f, input logic [4:0] r,
                                       input logic is_jump, input stage_t e,
                                       input stage_t m, input stage_t w);
    logic       stl;
    logic [1:0] sel;
    stl = 1'b0;
    sel = 2'd0;
    if (use_f) begin
      if (hit(e, r)) begin
        if (is_jump && e.src == SRC_PC8) sel = 2'd1;
        else                             stl = 1'b1;
      end else if (hit(m, r)) begin
        if (m.src == SRC_LOAD) stl = 1'b1;
        else                   sel = is_jump ? 2'd2 : 2'd1;
      end else if (hit(w, r)) begin
        sel = is_jump ? 2'd3 : 2'd2;
      end
    end
    return {stl, sel};
  endfunction

  function automatic logic [2:0] e_fwd(input logic use_f, input logic [4:0] r,
                                       input stage_t m, input stage_t w);
    logic       stl;
    logic [1:0] sel;
    stl = 1'b0;
    sel = 2'd0;
    if (use_f) begin
      if (hit(m, r)) begin
        if (m.src == SRC_LOAD) stl = 1'b1;
        else                   sel = 2'd1;
      end else if (hit(w, r)) begin
        sel = 2'd2;
      end
    end
    return {stl, sel};
  endfunction

  logic [2:0] f_rs_b, f_rt_b, f_rs_jr, f_rt_ji, f_rs_alu, f_rt_alu;
  logic       load_use;

  always_comb begin
    f_rs_b   = d_fwd(use_rs_bD,  rsD, 1'b0, e_q, m_q, w_q);
    f_rt_b   = d_fwd(use_rt_bD,  rtD, 1'b0, e_q, m_q, w_q);
    f_rs_jr  = d_fwd(use_rs_jrD, rsD, 1'b1, e_q, m_q, w_q);
    f_rt_ji  = d_fwd(use_rt_jiD, rtD, 1'b1, e_q, m_q, w_q);
    f_rs_alu = e_fwd(e_q.valid && use_rs_alu_e, rs_e, m_q, w_q);
    f_rt_alu = e_fwd(e_q.valid && use_rt_alu_e, rt_e, m_q, w_q);
    load_use = (e_q.src == SRC_LOAD) &&
               ((use_rs_aluD && hit(e_q, rsD)) || (use_rt_aluD && hit(e_q, rtD)));

    bypass_rs_b   = f_rs_b[1:0];
    bypass_rt_b   = f_rt_b[1:0];
    bypass_rs_jr  = f_rs_jr[1:0];
    bypass_rt_ji  = f_rt_ji[1:0];
    bypass_rs_alu = f_rs_alu[1:0];
    bypass_rt_alu = f_rt_alu[1:0];
    bypass_rt_mem = m_q.valid && use_rt_mem_m && hit(w_q, rt_m);
    stall  = f_rs_b[2] | f_rt_b[2] | f_rs_jr[2] | f_rt_ji[2] |
             f_rs_alu[2] | f_rt_alu[2] | load_use;
    flushE = stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q.valid <= 1'b0;
      m_q.valid <= 1'b0;
      w_q.valid <= 1'b0;
      stall_cnt <= '0;
    end else begin
      e_q          <= '{valid: !stall, dst: dstD, src: src_t'(srcD)};
      rs_e         <= rsD;
      rt_e         <= rtD;
      use_rs_alu_e <= use_rs_aluD;
      use_rt_alu_e <= use_rt_aluD;
      use_rt_mem_e <= use_rt_memD;
      m_q          <= e_q;
      rt_m         <= rt_e;
      use_rt_mem_m <= use_rt_mem_e;
      w_q          <= m_q;
      if (stall) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, jump/branch and store
// scenarios with hand-computed expectations.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rsD, rtD, dstD;
  logic        use_rs_bD, use_rt_bD, use_rs_jrD, use_rt_jiD;
  logic        use_rs_aluD, use_rt_aluD, use_rt_memD;
  logic [1:0]  srcD;
  logic [1:0]  bypass_rs_b, bypass_rt_b, bypass_rs_jr, bypass_rt_ji;
  logic [1:0]  bypass_rs_alu, bypass_rt_alu;
  logic        bypass_rt_mem, stall, flushE;
  logic [31:0] stall_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  localparam logic [6:0] U_BRS  = 7'b1000000;
  localparam logic [6:0] U_BRT  = 7'b0100000;
  localparam logic [6:0] U_JR   = 7'b0010000;
  localparam logic [6:0] U_JI   = 7'b0001000;
  localparam logic [6:0] U_ARS  = 7'b0000100;
  localparam logic [6:0] U_ART  = 7'b0000010;
  localparam logic [6:0] U_MEM  = 7'b0000001;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD),
    .use_rs_bD(use_rs_bD), .use_rt_bD(use_rt_bD),
    .use_rs_jrD(use_rs_jrD), .use_rt_jiD(use_rt_jiD),
    .use_rs_aluD(use_rs_aluD), .use_rt_aluD(use_rt_aluD),
    .use_rt_memD(use_rt_memD),
    .dstD(dstD), .srcD(srcD),
    .bypass_rs_b(bypass_rs_b), .bypass_rt_b(bypass_rt_b),
    .bypass_rs_jr(bypass_rs_jr), .bypass_rt_ji(bypass_rt_ji),
    .bypass_rs_alu(bypass_rs_alu), .bypass_rt_alu(bypass_rt_alu),
    .bypass_rt_mem(bypass_rt_mem),
    .stall(stall), .flushE(flushE), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] all_sel();
    return {bypass_rs_b, bypass_rt_b, bypass_rs_jr, bypass_rt_ji,
            bypass_rs_alu, bypass_rt_alu, bypass_rt_mem};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [6:0] u,
                       input logic [4:0] dst, input logic [1:0] src);
    rsD = rs; rtD = rt; dstD = dst; srcD = src;
    {use_rs_bD, use_rt_bD, use_rs_jrD, use_rt_jiD,
     use_rs_aluD, use_rt_aluD, use_rt_memD} = u;
  endtask

  task automatic nops(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      issue(5'd0, 5'd0, 7'd0, 5'd0, 2'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    issue(5'd0, 5'd0, 7'd0, 5'd0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_cnt", stall_cnt, 32'd0);
    chk("reset_sel", {19'd0, all_sel()}, 32'd0);

    // ALU producer $3 followed by two consumers of $3
    @(negedge clk); reset = 1'b0;
    issue(5'd1, 5'd2, U_ARS | U_ART, 5'd3, 2'd2); #1;
    chk("alu_prod_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); issue(5'd3, 5'd0, U_ARS, 5'd4, 2'd2); #1;
    chk("alu_cons1_nostall", {31'd0, stall}, 32'd0);
    @(negedge clk); issue(5'd3, 5'd0, U_ARS, 5'd5, 2'd2); #1;
    chk("alu_fwd_mem", {30'd0, bypass_rs_alu}, 32'd1);
    @(negedge clk); issue(5'd0, 5'd0, 7'd0, 5'd0, 2'd0); #1;
    chk("alu_fwd_wb", {30'd0, bypass_rs_alu}, 32'd2);
    nops(3);

    // load-use on rt
    @(negedge clk); issue(5'd1, 5'd0, U_ARS, 5'd5, 2'd3); #1;
    chk("lw_stall0", {31'd0, stall}, 32'd0);
    @(negedge clk); issue(5'd0, 5'd5, U_ART, 5'd6, 2'd2); #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_flush", {31'd0, flushE}, 32'd1);
    chk("lu_cnt_before", stall_cnt, 32'd0);
    @(negedge clk); #1;
    chk("lu_released", {31'd0, stall}, 32'd0);
    chk("lu_cnt_after", stall_cnt, 32'd1);
    @(negedge clk); issue(5'd0, 5'd0, 7'd0, 5'd0, 2'd0); #1;
    chk("lu_fwd_wb", {30'd0, bypass_rt_alu}, 32'd2);
    chk("lu_no_stall", {31'd0, stall}, 32'd0);
    nops(3);

    // jal -> jr, then jal -> beq/ji on $31
    @(negedge clk); issue(5'd0, 5'd0, 7'd0, 5'd31, 2'd1);
    @(negedge clk); issue(5'd31, 5'd0, U_JR, 5'd0, 2'd0); #1;
    chk("jr_pc8", {30'd0, bypass_rs_jr}, 32'd1);
    chk("jr_no_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); issue(5'd0, 5'd0, 7'd0, 5'd31, 2'd1);
    @(negedge clk); issue(5'd31, 5'd31, U_BRS | U_JI, 5'd0, 2'd0); #1;
    chk("beq_stall", {31'd0, stall}, 32'd1);
    chk("ji_pc8", {30'd0, bypass_rt_ji}, 32'd1);
    @(negedge clk); #1;
    chk("beq_released", {31'd0, stall}, 32'd0);
    chk("beq_fwd_mem", {30'd0, bypass_rs_b}, 32'd1);
    chk("ji_fwd_mem", {30'd0, bypass_rt_ji}, 32'd2);
    chk("beq_cnt", stall_cnt, 32'd2);
    nops(3);

    // lw $7 then sw $7: store data from write_data, never a stall
    @(negedge clk); issue(5'd1, 5'd0, U_ARS, 5'd7, 2'd3);
    @(negedge clk); issue(5'd1, 5'd7, U_ARS | U_MEM, 5'd0, 2'd0); #1;
    chk("sw_no_stall_d", {31'd0, stall}, 32'd0);
    @(negedge clk); issue(5'd0, 5'd0, 7'd0, 5'd0, 2'd0); #1;
    chk("sw_in_e_mem", {31'd0, bypass_rt_mem}, 32'd0);
    chk("sw_in_e_alu", {30'd0, bypass_rt_alu}, 32'd0);
    chk("sw_in_e_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); #1;
    chk("sw_in_m_fwd", {31'd0, bypass_rt_mem}, 32'd1);
    nops(3);

    // $0 is never forwarded
    @(negedge clk); issue(5'd0, 5'd0, 7'd0, 5'd0, 2'd2);
    @(negedge clk); issue(5'd0, 5'd0, 7'h7F, 5'd0, 2'd0); #1;
    chk("r0_e_stall", {31'd0, stall}, 32'd0);
    chk("r0_e_sel", {19'd0, all_sel()}, 32'd0);
    @(negedge clk); #1;
    chk("r0_m_sel", {19'd0, all_sel()}, 32'd0);
    @(negedge clk); #1;
    chk("r0_w_sel", {19'd0, all_sel()}, 32'd0);
    chk("r0_w_stall", {31'd0, stall}, 32'd0);
    nops(3);

    // reset asserted while stalling
    @(negedge clk); issue(5'd1, 5'd0, U_ARS, 5'd9, 2'd3);
    @(negedge clk); issue(5'd9, 5'd0, U_ARS, 5'd0, 2'd0); #1;
    chk("rst_pre_stall", {31'd0, stall}, 32'd1);
    chk("rst_pre_cnt", stall_cnt, 32'd2);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    chk("rst_post_stall", {31'd0, stall}, 32'd0);
    chk("rst_post_cnt", stall_cnt, 32'd0);
    chk("rst_post_sel", {19'd0, all_sel()}, 32'd0);
    @(negedge clk); issue(5'd0, 5'd0, 7'd0, 5'd0, 2'd0); #1;
    chk("rst_cons_sel", {30'd0, bypass_rs_alu}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
